pipe_mem_responder: RTL and testbench

Memory responder for the pipelined CPU's `imem`/`dmem` mask-based request interface. One instance serves one port: instruction fetch or data. It accepts one request per cycle, returns responses strictly in order after a fixed latency, and backs them with a byte-writable word array. It is the far end of the CPU's memory interface, used in simulation tops and in FPGA builds that have no cache.

---
 rtl/rv32i_types.sv | 22 ++
 rtl/mem_req_delay.sv | 42 ++++
 rtl/pipe_mem_responder.sv | 81 ++++++++
 tb/tb_pipe_mem_responder.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared CPU types: memory request bundle carried down the responder delay line.
package rv32i_types;

  localparam int MEM_MAX_LATENCY = 8;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] wdata;
    logic        valid;
  } mem_req_t;

  // Expand a 4-bit lane mask into a 32-bit bit mask.
  function automatic logic [31:0] byte_mask(input logic [3:0] m);
    logic [31:0] bm;
    bm = '0;
    for (int i = 0; i < 4; i++) bm[8*i +: 8] = {8{m[i]}};
    return bm;
  endfunction

endpackage

// File: rtl/mem_req_delay.sv
// In-order LATENCY-1 stage delay line for memory requests; pass-through when LATENCY=1.
module mem_req_delay
  import rv32i_types::*;
#(
  parameter int LATENCY = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  input  mem_req_t req_in,
  output mem_req_t req_out
);

  localparam int STAGES = LATENCY - 1;

  if (STAGES == 0) begin : g_pass
    assign req_out = req_in;
  end else begin : g_line
    mem_req_t          pipe [1:STAGES];
    logic [STAGES:1]   vld_pipe;

    // Payload needs no reset; only the valid bits decide what is in flight.
    always_ff @(posedge clk) begin
      pipe[1] <= req_in;
      for (int s = 2; s <= STAGES; s++) pipe[s] <= pipe[s-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_pipe <= '0;
      end else begin
        vld_pipe[1] <= req_in.valid;
        for (int s = 2; s <= STAGES; s++) vld_pipe[s] <= vld_pipe[s-1];
      end
    end

    always_comb begin
      req_out       = pipe[STAGES];
      req_out.valid = vld_pipe[STAGES];
    end
  end

endmodule

// File: rtl/pipe_mem_responder.sv
// Fixed-latency, in-order memory responder for the CPU imem/dmem mask interface.
module pipe_mem_responder
  import rv32i_types::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          WORDS     = 1024,
  parameter int          LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] mem_addr,
  input  logic [3:0]  mem_rmask,
  input  logic [3:0]  mem_wmask,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_resp,
  output logic        mem_err
);

  localparam int AW = (WORDS > 1) ? $clog2(WORDS) : 1;

  if (LATENCY < 1 || LATENCY > MEM_MAX_LATENCY) begin : g_bad_latency
    $error("pipe_mem_responder: LATENCY out of range");
  end

  mem_req_t    req, acc;
  logic [31:0] mem [WORDS];

  // Gating with rst_n keeps a LATENCY=1 build from writing while held in reset.
  always_comb begin
    req.addr  = mem_addr;
    req.rmask = mem_rmask;
    req.wmask = mem_wmask;
    req.wdata = mem_wdata;
    req.valid = rst_n && (|(mem_rmask | mem_wmask));
  end

  mem_req_delay #(.LATENCY(LATENCY)) u_delay (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_in  (req),
    .req_out (acc)
  );

  logic [29:0]   word_off;
  logic [AW-1:0] idx;
  logic          in_range, aligned, ok, has_r, has_w, do_write, err_nxt;
  logic [31:0]   rdata_nxt;

  assign word_off = 30'((acc.addr - BASE_ADDR) >> 2);
  assign idx      = word_off[AW-1:0];
  assign in_range = (acc.addr >= BASE_ADDR) && ({2'b00, word_off} < 32'(WORDS));
  assign aligned  = (acc.addr[1:0] == 2'b00);
  assign ok       = in_range && aligned;
  assign has_r    = |acc.rmask;
  assign has_w    = |acc.wmask;
  assign do_write = acc.valid && ok && has_w;
  assign err_nxt  = acc.valid && (!ok || (has_r && has_w));
  // Read sees the pre-write word, so a combined access returns old data.
  assign rdata_nxt = (acc.valid && ok && has_r) ? (mem[idx] & byte_mask(acc.rmask)) : '0;

  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < 4; i++)
        if (acc.wmask[i]) mem[idx][8*i +: 8] <= acc.wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_resp  <= 1'b0;
      mem_rdata <= '0;
      mem_err   <= 1'b0;
    end else begin
      mem_resp  <= acc.valid;
      mem_rdata <= rdata_nxt;
      mem_err   <= err_nxt;
    end
  end

endmodule

// File: tb/tb_pipe_mem_responder.sv
// Scoreboard bench: four responders (LATENCY 1,2,4,8) share one stimulus stream.
module tb_pipe_mem_responder;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          WORDS = 64;
  localparam int          NL    = 4;

  typedef struct packed {
    int                   issue;
    logic                 err;
    logic [NL-1:0][31:0]  rd;
  } exp_t;

  typedef struct {
    int          d;
    int          idx;
    logic [31:0] old;
    int          commit;
  } jrn_t;

  logic        clk = 1'b0, rst_n = 1'b1;
  logic [31:0] mem_addr = '0, mem_wdata = '0;
  logic [3:0]  mem_rmask = '0, mem_wmask = '0;
  logic [NL-1:0]        resp, err;
  logic [NL-1:0][31:0]  rdata;

  int   cyc = 0, compared = 0, mismatched = 0;
  bit   mon_on = 1'b0;
  exp_t exp_q[$];
  int   ptr [NL];
  logic [31:0] mm [NL][WORDS];
  jrn_t jrn[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NL; g++) begin : g_dut
    pipe_mem_responder #(.BASE_ADDR(BASE), .WORDS(WORDS), .LATENCY(1 << g)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mem_addr  (mem_addr),
      .mem_rmask (mem_rmask),
      .mem_wmask (mem_wmask),
      .mem_wdata (mem_wdata),
      .mem_rdata (rdata[g]),
      .mem_resp  (resp[g]),
      .mem_err   (err[g])
    );
  end

  function automatic int lat(input int d);
    return 1 << d;
  endfunction

  // Drive one request for the current cycle and record what every instance owes.
  task automatic req(input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm,
                     input logic [31:0] wd);
    exp_t        e;
    logic [31:0] old;
    int          idx;
    bit          ok;
    mem_addr = a; mem_rmask = rm; mem_wmask = wm; mem_wdata = wd;
    if ((rm | wm) != 4'h0) begin
      ok    = (a >= BASE) && (((a - BASE) / 4) < WORDS) && (a % 4 == 0);
      idx   = ok ? int'((a - BASE) / 4) : 0;
      e     = '0;
      e.issue = cyc;
      e.err   = !ok || (rm != 4'h0 && wm != 4'h0);
      for (int d = 0; d < NL; d++) begin
        if (ok) begin
          old = mm[d][idx];
          for (int b = 0; b < 4; b++)
            if (rm[b]) e.rd[d][8*b +: 8] = old[8*b +: 8];
          if (wm != 4'h0) begin
            jrn.push_back('{d, idx, old, cyc + lat(d)});
            for (int b = 0; b < 4; b++)
              if (wm[b]) mm[d][idx][8*b +: 8] = wd[8*b +: 8];
          end
        end
      end
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) req(32'h0, 4'h0, 4'h0, 32'h0);
  endtask

  // One-cycle reset pulse; writes that had not yet reached their commit edge are undone.
  task automatic mid_reset();
    int r;
    @(negedge clk); #1;
    r = cyc;
    rst_n = 1'b0;
    for (int k = jrn.size() - 1; k >= 0; k--)
      if (jrn[k].commit > r) mm[jrn[k].d][jrn[k].idx] = jrn[k].old;
    jrn.delete();
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        for (int d = 0; d < NL; d++) begin
          if (!rst_n) begin
            compared++;
            if (resp[d] || err[d] || rdata[d] != 32'h0) begin
              mismatched++;
              $display("FAIL reset_outputs L=%0d: resp=%b err=%b rdata=%h, want all 0",
                       lat(d), resp[d], err[d], rdata[d]);
            end
            ptr[d] = exp_q.size();
          end else if (resp[d]) begin
            compared++;
            if (ptr[d] >= exp_q.size()) begin
              mismatched++;
              $display("FAIL unexpected_resp L=%0d cyc=%0d: rdata=%h err=%b, want no response",
                       lat(d), cyc, rdata[d], err[d]);
            end else begin
              e = exp_q[ptr[d]];
              ptr[d]++;
              if (e.issue + lat(d) != cyc || rdata[d] != e.rd[d] || err[d] != e.err) begin
                mismatched++;
                $display("FAIL resp L=%0d issue=%0d: got cyc=%0d rdata=%h err=%b, want cyc=%0d rdata=%h err=%b",
                         lat(d), e.issue, cyc, rdata[d], err[d], e.issue + lat(d), e.rd[d], e.err);
              end
            end
          end else begin
            compared++;
            if (err[d] || rdata[d] != 32'h0) begin
              mismatched++;
              $display("FAIL idle_outputs L=%0d cyc=%0d: err=%b rdata=%h, want 0",
                       lat(d), cyc, err[d], rdata[d]);
            end
            if (ptr[d] < exp_q.size() && exp_q[ptr[d]].issue + lat(d) <= cyc) begin
              compared++;
              mismatched++;
              $display("FAIL missing_resp L=%0d issue=%0d: no response by cyc=%0d, want cyc=%0d",
                       lat(d), exp_q[ptr[d]].issue, cyc, exp_q[ptr[d]].issue + lat(d));
              ptr[d]++;
            end
          end
        end
      end
    end
  end

  initial begin : stimulus
    logic [31:0] a;
    logic [3:0]  rm, wm;
    int          w, c;
    for (int d = 0; d < NL; d++) ptr[d] = 0;
    #2 rst_n = 1'b0;
    mon_on = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // preload every word through the port; word 0x10 gets the known pattern
    for (int i = 0; i < WORDS; i++)
      req(BASE + 32'(4 * i), 4'h0, 4'hF, (i == 16) ? 32'hDEAD_BEEF : $urandom);
    idle(2);

    req(BASE + 32'h40, 4'hF, 4'h0, 32'h0);
    req(BASE + 32'h40, 4'h6, 4'h0, 32'h0);
    idle(1);
    req(BASE + 32'h40, 4'h0, 4'h3, 32'h1234_5678);
    req(BASE + 32'h40, 4'hF, 4'h0, 32'h0);
    idle(3);

    for (int i = 0; i < 16; i++) req(BASE + 32'(4 * i), 4'hF, 4'h0, 32'h0);
    idle(2);

    req(BASE + 32'h41, 4'hF, 4'h0, 32'h0);
    req(BASE + 32'h42, 4'h0, 4'hF, 32'hFFFF_FFFF);
    req(BASE + 32'(4 * WORDS), 4'hF, 4'h0, 32'h0);
    req(BASE - 32'h4, 4'hF, 4'h0, 32'h0);
    req(BASE + 32'(4 * WORDS), 4'h0, 4'hF, 32'h5555_5555);
    req(BASE + 32'h40, 4'hF, 4'h0, 32'h0);
    req(BASE + 32'h40, 4'hF, 4'hF, 32'h0);
    req(BASE + 32'h40, 4'hF, 4'h0, 32'h0);
    idle(2);

    for (int i = 0; i < 400; i++) begin
      w = $urandom_range(0, WORDS + 3);
      a = BASE + 32'(4 * w);
      if ($urandom_range(0, 9) == 0) a = a + 32'($urandom_range(1, 3));
      if ($urandom_range(0, 19) == 0) a = BASE - 32'(4 * $urandom_range(1, 4));
      case ($urandom_range(0, 9))
        0, 1:    begin rm = 4'h0; wm = 4'h0; end
        2, 3, 4: begin rm = 4'($urandom_range(1, 15)); wm = 4'h0; end
        5, 6, 7, 8: begin rm = 4'h0; wm = 4'($urandom_range(1, 15)); end
        default: begin rm = 4'($urandom_range(1, 15)); wm = 4'($urandom_range(1, 15)); end
      endcase
      req(a, rm, wm, $urandom);
    end
    idle(10);

    // three writes in flight, reset right after the LATENCY=4 copy commits the first
    c = cyc;
    req(BASE + 32'd80, 4'h0, 4'hF, 32'hA1A1_0001);
    req(BASE + 32'd84, 4'h0, 4'hF, 32'hA2A2_0002);
    req(BASE + 32'd88, 4'h0, 4'hF, 32'hA3A3_0003);
    while (cyc < c + 4) idle(1);
    mid_reset();
    idle(2);
    req(BASE + 32'd80, 4'hF, 4'h0, 32'h0);
    req(BASE + 32'd84, 4'hF, 4'h0, 32'h0);
    req(BASE + 32'd88, 4'hF, 4'h0, 32'h0);
    idle(12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
